// File: rtl/wb_fir_pkg.sv
// wb_fir_pkg: shared states, address map and defaults for the WB-to-FIR sequencer
package wb_fir_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE    = 3'd0;
    localparam state_t LW      = 3'd1;
    localparam state_t LR_A    = 3'd2;
    localparam state_t LR_D    = 3'd3;
    localparam state_t SS_PUSH = 3'd4;
    localparam state_t SM_POP  = 3'd5;
    localparam state_t ACK     = 3'd6;
    localparam logic [7:0] WB_PREFIX = 8'h30;
    localparam logic [7:0] SS_ADDR   = 8'h80;
    localparam logic [7:0] SM_ADDR   = 8'h84;
    localparam logic [7:0] LEN_ADDR  = 8'h10;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/wb_fir_axi_sequencer_axi_hs_timer.sv
// axi_hs_timer: counts waiting cycles and flags the last one allowed before abort
module axi_hs_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    assign expired = en && (cnt == W'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/wb_fir_axi_sequencer.sv
// wb_fir_axi_sequencer: turns each Wishbone cycle into one AXI-Lite or AXI-Stream transaction
module wb_fir_axi_sequencer
    import wb_fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int TIMEOUT = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   awvalid,
    output logic                   wvalid,
    output logic                   arvalid,
    output logic                   rready,
    input  logic                   awready,
    input  logic                   wready,
    input  logic                   arready,
    input  logic                   rvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic [pADDR_WIDTH-1:0] araddr,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   ss_tvalid,
    output logic                   ss_tlast,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tready,
    input  logic                   sm_tvalid,
    input  logic                   sm_tlast,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tready,
    output logic                   timeout_err
);
    state_t state, state_n, dec;
    logic [pADDR_WIDTH-1:0] adr_q;
    logic [pDATA_WIDTH-1:0] dat_q, len_q, cnt_q;
    logic [31:0] rd_q;
    logic aw_done, w_done, valid, lw_done, hs_done, wait_st, expired, tmo;
    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i, sm_tlast};
    assign valid = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:24] == WB_PREFIX);
    assign dec = (wbs_adr_i[7:0] == SS_ADDR && wbs_we_i) ? SS_PUSH :
                 (wbs_adr_i[7:0] == SM_ADDR && !wbs_we_i) ? SM_POP :
                 !wbs_adr_i[7] ? (wbs_we_i ? LW : LR_A) : ACK;
    assign lw_done = (aw_done || awready) && (w_done || wready);
    assign wait_st = state inside {LW, LR_A, LR_D, SS_PUSH, SM_POP};
    assign hs_done = (state == LW) ? lw_done :
                     (state == LR_A) ? arready :
                     (state == LR_D) ? rvalid :
                     (state == SS_PUSH) ? ss_tready :
                     (state == SM_POP) ? sm_tvalid : 1'b0;
    assign tmo = wait_st && !hs_done && expired;
    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = valid ? dec : IDLE;
        else if (state == ACK) state_n = IDLE;
        else if (tmo) state_n = ACK;
        else if (hs_done) state_n = (state == LR_A) ? LR_D : ACK;
    end
    axi_hs_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(wb_clk_i),
        .rst(wb_rst_i),
        .clr(state_n != state),
        .en(wait_st),
        .expired(expired)
    );
    assign awvalid   = (state == LW) && !aw_done;
    assign wvalid    = (state == LW) && !w_done;
    assign awaddr    = adr_q;
    assign wdata     = dat_q;
    assign arvalid   = state == LR_A;
    assign araddr    = adr_q;
    assign rready    = state == LR_D;
    assign ss_tvalid = state == SS_PUSH;
    assign ss_tdata  = dat_q;
    assign ss_tlast  = ss_tvalid && (len_q != '0) && (cnt_q == len_q - 1'b1);
    assign sm_tready = state == SM_POP;
    assign wbs_ack_o = state == ACK;
    assign wbs_dat_o = wbs_ack_o ? rd_q : '0;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            rd_q        <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                rd_q    <= '0;
                if (valid) begin
                    adr_q <= wbs_adr_i[pADDR_WIDTH-1:0];
                    dat_q <= wbs_dat_i[pDATA_WIDTH-1:0];
                end
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready) w_done <= 1'b1;
            if (state == LW && lw_done && adr_q == pADDR_WIDTH'(LEN_ADDR)) len_q <= dat_q;
            if (rready && rvalid) rd_q <= 32'(rdata);
            if (sm_tready && sm_tvalid) rd_q <= 32'(sm_tdata);
            // the sample counter wraps after the last beat of each frame
            if (ss_tvalid && ss_tready) cnt_q <= ss_tlast ? '0 : cnt_q + 1'b1;
            if (tmo) begin
                timeout_err <= 1'b1;
                if (state inside {LR_A, LR_D, SM_POP}) rd_q <= ERR_DATA;
            end
        end
    end
endmodule

// File: tb/tb_wb_fir_axi_sequencer.sv
// tb_wb_fir_axi_sequencer: table-driven scoreboard bench with a delay-programmable AXI responder
module tb_wb_fir_axi_sequencer;
    localparam int T = 255;
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          da;
        int          db;
        logic [31:0] rd_in;
        logic [31:0] exp_dat;
        int          exp_lat;
        logic [1:0]  kind;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;
    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    logic wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0] wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic awvalid, wvalid, arvalid, rready, awready, wready, arready, rvalid;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata, ss_tdata, sm_tdata;
    logic ss_tvalid, ss_tlast, ss_tready, sm_tvalid, sm_tready, timeout_err;
    logic sm_tlast = 1'b0;
    int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, ss_dly = 0, sm_dly = 0;
    int aw_c = 0, w_c = 0, ar_c = 0, r_c = 0, ss_c = 0, sm_c = 0;
    logic [31:0] rd_in = '0;
    logic [31:0] obs_a, obs_b;
    int sm_pulses = 0;
    int pass = 0, total = 0;
    vec_t tbl[14];
    vec_t exp_q[$];
    vec_t tv;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_fir_axi_sequencer dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .awvalid(awvalid), .wvalid(wvalid), .arvalid(arvalid), .rready(rready),
        .awready(awready), .wready(wready), .arready(arready), .rvalid(rvalid),
        .awaddr(awaddr), .araddr(araddr), .wdata(wdata), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast), .sm_tdata(sm_tdata), .sm_tready(sm_tready),
        .timeout_err(timeout_err)
    );

    assign awready   = awvalid && (aw_c >= aw_dly);
    assign wready    = wvalid && (w_c >= w_dly);
    assign arready   = arvalid && (ar_c >= ar_dly);
    assign rvalid    = rready && (r_c >= r_dly);
    assign ss_tready = ss_tvalid && (ss_c >= ss_dly);
    assign sm_tvalid = sm_tready && (sm_c >= sm_dly);
    assign rdata     = rd_in;
    assign sm_tdata  = rd_in;

    always @(posedge wb_clk_i) begin
        aw_c <= awvalid ? aw_c + 1 : 0;
        w_c  <= wvalid ? w_c + 1 : 0;
        ar_c <= arvalid ? ar_c + 1 : 0;
        r_c  <= rready ? r_c + 1 : 0;
        ss_c <= ss_tvalid ? ss_c + 1 : 0;
        sm_c <= sm_tready ? sm_c + 1 : 0;
    end

    always @(negedge wb_clk_i) begin
        if (awvalid && awready) obs_a = 32'(awaddr);
        if (wvalid && wready) obs_b = wdata;
        if (ss_tvalid && ss_tready) begin
            obs_a = ss_tdata;
            obs_b = {31'b0, ss_tlast};
        end
        if (sm_tready) sm_pulses++;
    end

    task automatic chk(input int idx, input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL v%0d %s: got %h expected %h", idx, n, act, exp);
    endtask

    task automatic run(input vec_t v, input int idx);
        int lat;
        logic got;
        logic [31:0] rd;
        vec_t e;
        aw_dly = v.da; ar_dly = v.da; ss_dly = v.da; sm_dly = v.da;
        w_dly = v.db; r_dly = v.db; rd_in = v.rd_in;
        obs_a = '1; obs_b = '1;
        exp_q.push_back(v);
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = v.we; wbs_adr_i = v.adr; wbs_dat_i = v.dat;
        lat = 0; got = 1'b0; rd = '0;
        while (!got && lat < T + 50) begin
            @(negedge wb_clk_i);
            lat++;
            if (wbs_ack_o) begin
                got = 1'b1;
                rd = wbs_dat_o;
            end
        end
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        e = exp_q.pop_front();
        chk(idx, "ack", {31'b0, got}, 32'd1);
        chk(idx, "dat", rd, e.exp_dat);
        chk(idx, "lat", lat, e.exp_lat);
        if (e.kind != 2'd0) begin
            chk(idx, "obs_a", obs_a, e.exp_a);
            chk(idx, "obs_b", obs_b, e.exp_b);
        end
        chk(idx, "post_ack", wbs_dat_o | {31'b0, wbs_ack_o}, 32'd0);
    endtask

    function automatic logic [31:0] outs_or();
        return {31'b0, |{wbs_ack_o, wbs_dat_o, awvalid, wvalid, arvalid, rready, awaddr, araddr,
                         wdata, ss_tvalid, ss_tlast, ss_tdata, sm_tready, timeout_err}};
    endfunction

    initial begin
        int acks;
        tbl[0]  = '{1'b1, 32'h3000_0040, 32'h5,      2, 0, 32'h0,         32'h0,         5, 2'd1, 32'h040,  32'h5};
        tbl[1]  = '{1'b1, 32'h3000_0010, 32'h3,      0, 0, 32'h0,         32'h0,         3, 2'd1, 32'h010,  32'h3};
        tbl[2]  = '{1'b1, 32'h3000_0080, 32'h1,      0, 0, 32'h0,         32'h0,         3, 2'd2, 32'h1,    32'h0};
        tbl[3]  = '{1'b1, 32'h3000_0080, 32'h2,      0, 0, 32'h0,         32'h0,         3, 2'd2, 32'h2,    32'h0};
        tbl[4]  = '{1'b1, 32'h3000_0080, 32'h3,      0, 0, 32'h0,         32'h0,         3, 2'd2, 32'h3,    32'h1};
        tbl[5]  = '{1'b1, 32'h3000_0080, 32'h4,      0, 0, 32'h0,         32'h0,         3, 2'd2, 32'h4,    32'h0};
        tbl[6]  = '{1'b0, 32'h3000_0000, 32'h0,      0, 4, 32'h6,         32'h6,         8, 2'd0, 32'h0,    32'h0};
        tbl[7]  = '{1'b0, 32'h3000_0084, 32'h0,      0, 0, 32'h1234,      32'h1234,      3, 2'd0, 32'h0,    32'h0};
        tbl[8]  = '{1'b0, 32'h3000_0088, 32'h0,      0, 0, 32'h5555,      32'h0,         2, 2'd0, 32'h0,    32'h0};
        tbl[9]  = '{1'b1, 32'h3000_0044, 32'hA5A5,   0, 3, 32'h0,         32'h0,         6, 2'd1, 32'h044,  32'hA5A5};
        tbl[10] = '{1'b0, 32'h3000_0008, 32'h0,      2, 0, 32'hCAFE_0001, 32'hCAFE_0001, 6, 2'd0, 32'h0,    32'h0};
        tbl[11] = '{1'b1, 32'h3000_0080, 32'h5,      1, 0, 32'h0,         32'h0,         4, 2'd2, 32'h5,    32'h0};
        tbl[12] = '{1'b1, 32'h3000_0080, 32'h6,      0, 0, 32'h0,         32'h0,         3, 2'd2, 32'h6,    32'h1};
        tbl[13] = '{1'b1, 32'h3000_0084, 32'h99,     0, 0, 32'h0,         32'h0,         2, 2'd0, 32'h0,    32'h0};
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk(100, "reset_outs", outs_or(), 32'd0);
        for (int i = 0; i < 14; i++) run(tbl[i], i);
        sm_pulses = 0;
        run(tbl[7], 20);
        chk(20, "sm_tready_pulses", sm_pulses, 32'd1);
        chk(21, "err_clear", {31'b0, timeout_err}, 32'd0);
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_adr_i = 32'h2000_0040;
        acks = 0;
        repeat (8) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o || arvalid) acks++;
        end
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        chk(22, "bad_prefix_ignored", acks, 32'd0);
        tv = '{1'b1, 32'h3000_0080, 32'h77, 1000, 0, 32'h0, 32'h0, T + 2, 2'd0, 32'h0, 32'h0};
        run(tv, 23);
        chk(23, "timeout_err", {31'b0, timeout_err}, 32'd1);
        chk(23, "ss_tvalid_drop", {31'b0, ss_tvalid}, 32'd0);
        run(tbl[7], 24);
        tv = '{1'b0, 32'h3000_0004, 32'h0, 1000, 0, 32'h0, 32'hDEAD_BEEF, T + 2, 2'd0, 32'h0, 32'h0};
        run(tv, 25);
        chk(25, "timeout_err_sticky", {31'b0, timeout_err}, 32'd1);
        aw_dly = 1000; w_dly = 0;
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = 32'h3000_0040; wbs_dat_i = 32'h9;
        repeat (3) @(negedge wb_clk_i);
        chk(26, "awvalid_before_rst", {31'b0, awvalid}, 32'd1);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk(26, "mid_rst_outs", outs_or(), 32'd0);
        @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
        run(tbl[7], 27);
        tv = '{1'b1, 32'h3000_0080, 32'h11, 0, 0, 32'h0, 32'h0, 3, 2'd2, 32'h11, 32'h0};
        run(tv, 28);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
